// File: rtl/gnr_pkg.sv
// gnr_pkg: shared definitions for the GNR cycle controller slice.
// Contents: sequencer FSM state enum and the default counter width.
package gnr_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    STEP1 = 3'd2,
    CHK1  = 3'd3,
    STEP2 = 3'd4,
    CHK2  = 3'd5,
    DONE  = 3'd6
  } gnr_state_t;

endpackage

// File: rtl/gnr_cycle_ctrl_if.sv
// gnr_cycle_ctrl_if: host-side request/result bundle of gnr_cycle_ctrl.
//   start, init_in                          : request (host -> controller)
//   busy, done, meet_step, period, timeout  : status and results (controller -> host)
// Modports: master = host, slave = controller.
interface gnr_cycle_ctrl_if #(
  parameter int NUM_NODES = 8,
  parameter int CNT_W     = 16
);
  logic                 start;
  logic [NUM_NODES-1:0] init_in;
  logic                 busy;
  logic                 done;
  logic [CNT_W-1:0]     meet_step;
  logic [CNT_W-1:0]     period;
  logic                 timeout;

  modport master (
    output start, init_in,
    input  busy, done, meet_step, period, timeout
  );

  modport slave (
    input  start, init_in,
    output busy, done, meet_step, period, timeout
  );
endinterface

// File: rtl/gnr_vec_cmp.sv
// gnr_vec_cmp: purely combinational equality compare of two state vectors.
// Ports:
//   a, b : W-bit vectors (cas_s0 / cas_s1 readback)
//   eq   : 1 when a == b
module gnr_vec_cmp #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq
);

  assign eq = (a == b);

endmodule

// File: rtl/gnr_cycle_ctrl.sv
// gnr_cycle_ctrl: sequencer and Floyd tortoise/hare attractor detector for a
// GNR node array with dual state tracks (s0 tortoise, s1 hare).
//
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   host (slave modport)   : start/init_in request, busy/done/meet_step/period/timeout
//   state_s0, state_s1     : concatenated node cas_s0 / cas_s1 readback
//   init_state             : registered initial state driven to every node
//   reset_nos              : node reload strobe
//   start_s0, start_s1     : tortoise / hare step strobes
//
// Build option: define GNR_CYCLE_TIMEOUT_EN to bound each phase to MAX_STEPS
// steps; otherwise there is no limit check and timeout is tied low.
//
// state | meaning
// IDLE  | waiting for start; results held
// INIT  | reset_nos high, nodes load init_state into both tracks
// STEP1 | start_s0 + start_s1 high, k advances
// CHK1  | compare tracks (only when k is even)
// STEP2 | start_s1 only, tortoise frozen, p advances
// CHK2  | compare tracks to find the period
// DONE  | one-cycle done pulse
module gnr_cycle_ctrl
  import gnr_pkg::*;
#(
  parameter int NUM_NODES = 8,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int MAX_STEPS = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  gnr_cycle_ctrl_if.slave      host,
  input  logic [NUM_NODES-1:0] state_s0,
  input  logic [NUM_NODES-1:0] state_s1,
  output logic [NUM_NODES-1:0] init_state,
  output logic                 reset_nos,
  output logic                 start_s0,
  output logic                 start_s1
);

  // Configuration sanity: k must be able to reach 2*(transient+period)
  // for any state vector, and the limit must be representable in k/p.
  if (CNT_W < NUM_NODES + 2) begin : g_bad_cnt_w
    $error("gnr_cycle_ctrl: CNT_W must be at least NUM_NODES+2");
  end
  if (MAX_STEPS < 1 || MAX_STEPS >= (2 ** CNT_W)) begin : g_bad_max_steps
    $error("gnr_cycle_ctrl: MAX_STEPS out of range for CNT_W");
  end

  gnr_state_t       state;
  logic [CNT_W-1:0] k;
  logic [CNT_W-1:0] p;
  logic [CNT_W-1:0] meet_step_r;
  logic [CNT_W-1:0] period_r;
  logic             busy_r;
  logic             done_r;
  logic             tracks_eq;

`ifdef GNR_CYCLE_TIMEOUT_EN
  localparam logic [CNT_W-1:0] STEP_LIMIT = CNT_W'(MAX_STEPS);
  logic timeout_r;
  assign host.timeout = timeout_r;
`else
  assign host.timeout = 1'b0;
`endif

  assign host.busy      = busy_r;
  assign host.done      = done_r;
  assign host.meet_step = meet_step_r;
  assign host.period    = period_r;

  gnr_vec_cmp #(.W(NUM_NODES)) u_cmp (
    .a  (state_s0),
    .b  (state_s1),
    .eq (tracks_eq)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      p           <= '0;
      meet_step_r <= '0;
      period_r    <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      init_state  <= '0;
      reset_nos   <= 1'b0;
      start_s0    <= 1'b0;
      start_s1    <= 1'b0;
`ifdef GNR_CYCLE_TIMEOUT_EN
      timeout_r   <= 1'b0;
`endif
    end else begin
      // Strobes and done are single-cycle; each transition re-arms the one it needs.
      reset_nos <= 1'b0;
      start_s0  <= 1'b0;
      start_s1  <= 1'b0;
      done_r    <= 1'b0;

      unique case (state)
        IDLE: begin
          if (host.start) begin
            init_state  <= host.init_in;
            k           <= '0;
            p           <= '0;
            meet_step_r <= '0;
            period_r    <= '0;
`ifdef GNR_CYCLE_TIMEOUT_EN
            timeout_r   <= 1'b0;
`endif
            busy_r      <= 1'b1;
            reset_nos   <= 1'b1;
            state       <= INIT;
          end
        end

        INIT: begin
          start_s0 <= 1'b1;
          start_s1 <= 1'b1;
          state    <= STEP1;
        end

        STEP1: begin
          k     <= k + 1'b1;
          state <= CHK1;
        end

        CHK1: begin
          // Odd k: tortoise is still half a step behind, so no compare.
          if (!k[0] && tracks_eq) begin
            meet_step_r <= k;
            start_s1    <= 1'b1;
            state       <= STEP2;
          end
`ifdef GNR_CYCLE_TIMEOUT_EN
          else if (k == STEP_LIMIT) begin
            timeout_r <= 1'b1;
            period_r  <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            state     <= DONE;
          end
`endif
          else begin
            start_s0 <= 1'b1;
            start_s1 <= 1'b1;
            state    <= STEP1;
          end
        end

        STEP2: begin
          p     <= p + 1'b1;
          state <= CHK2;
        end

        CHK2: begin
          if (tracks_eq) begin
            period_r <= p;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state    <= DONE;
          end
`ifdef GNR_CYCLE_TIMEOUT_EN
          else if (p == STEP_LIMIT) begin
            timeout_r <= 1'b1;
            period_r  <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            state     <= DONE;
          end
`endif
          else begin
            start_s1 <= 1'b1;
            state    <= STEP2;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gnr_cycle_ctrl.sv
// tb_gnr_cycle_ctrl: self-checking bench for gnr_cycle_ctrl. A behavioural
// node-array plant applies a lookup-table map F; the reference model finds the
// meeting step and period by evaluating F^n directly.
module tb_gnr_cycle_ctrl;

  localparam int NN = 8;
  localparam int CW = 16;
`ifdef GNR_CYCLE_TIMEOUT_EN
  localparam int  MAXS  = 10;
  localparam bit  TO_EN = 1'b1;
`else
  localparam int  MAXS  = 1000;
  localparam bit  TO_EN = 1'b0;
`endif
  localparam int WAIT_LIMIT = 5000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gnr_cycle_ctrl_if #(.NUM_NODES(NN), .CNT_W(CW)) host ();

  logic [NN-1:0] state_s0, state_s1, init_state;
  logic          reset_nos, start_s0, start_s1;

  gnr_cycle_ctrl #(.NUM_NODES(NN), .CNT_W(CW), .MAX_STEPS(MAXS)) dut (
    .clk        (clk),
    .rst        (rst),
    .host       (host),
    .state_s0   (state_s0),
    .state_s1   (state_s1),
    .init_state (init_state),
    .reset_nos  (reset_nos),
    .start_s0   (start_s0),
    .start_s1   (start_s1)
  );

  // Node array plant: s1 advances on every start_s1, s0 on every other start_s0.
  logic [NN-1:0] f_tab [256];
  logic          pass;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_s0 <= '0;
      state_s1 <= '0;
      pass     <= 1'b0;
    end else if (reset_nos) begin
      state_s0 <= init_state;
      state_s1 <= init_state;
      pass     <= 1'b1;
    end else begin
      if (start_s1) state_s1 <= f_tab[state_s1];
      if (start_s0) begin
        pass <= ~pass;
        if (pass) state_s0 <= f_tab[state_s0];
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int last_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NN-1:0] f_pow(input logic [NN-1:0] x, input int n);
    logic [NN-1:0] v;
    v = x;
    for (int i = 0; i < n; i++) v = f_tab[v];
    return v;
  endfunction

  // Reference: smallest even k with F^k(x0)==F^(k/2)(x0), then smallest p>0 with
  // F^(k+p)(x0)==F^(k/2)(x0); done arrives 2 + 2*k_steps + 2*p_steps cycles after start.
  task automatic model(input logic [NN-1:0] x0, output int m, output int per,
                       output int to, output int lat);
    int kk, q;
    bit found;
    m = 0; per = 0; to = 0; found = 0; kk = 0; q = 0;
    for (int n = 1; n <= 4000; n++) begin
      kk = n;
      if ((n % 2) == 0 && f_pow(x0, n) == f_pow(x0, n / 2)) begin
        m = n; found = 1; break;
      end
      if (TO_EN && n == MAXS) begin
        to = 1; break;
      end
    end
    if (found) begin
      for (int n = 1; n <= 4000; n++) begin
        q = n;
        if (f_pow(x0, m + n) == f_pow(x0, m / 2)) begin
          per = n; break;
        end
        if (TO_EN && n == MAXS) begin
          to = 1; break;
        end
      end
    end
    lat = 2 + 2 * kk + 2 * q;
  endtask

  task automatic run_case(input string tag, input logic [NN-1:0] x0,
                          input bit inj_start, input bit rst_step2);
    int m, per, to, lat, cyc;
    bit proto_bad, busy_bad;
    model(x0, m, per, to, lat);
    proto_bad = 0; busy_bad = 0;
    host.start   = 1'b1;
    host.init_in = x0;
    @(posedge clk); #1;
    host.start = 1'b0;
    cyc = 1;
    chk({tag, "_reset_nos"}, 64'(reset_nos), 64'd1);
    chk({tag, "_init_state"}, 64'(init_state), 64'(x0));
    while (!host.done && cyc < WAIT_LIMIT) begin
      if (reset_nos && (start_s0 || start_s1)) proto_bad = 1;
      if (!host.busy) busy_bad = 1;
      if (inj_start && cyc == 2) begin
        host.start   = 1'b1;
        host.init_in = ~x0;
      end
      if (inj_start && cyc == 3) host.start = 1'b0;
      if (rst_step2 && start_s1 && !start_s0 && !reset_nos) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk({tag, "_rst_outputs"},
            64'({host.busy, host.done, host.meet_step, host.period, host.timeout,
                 init_state, reset_nos, start_s0, start_s1}), 64'd0);
        chk({tag, "_proto"}, 64'({proto_bad, busy_bad}), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_no_done_after_rst"}, 64'({host.done, host.busy}), 64'd0);
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
    last_cyc = cyc;
    chk({tag, "_done"}, 64'(host.done), 64'd1);
    chk({tag, "_latency"}, 64'(cyc), 64'(lat));
    chk({tag, "_meet_step"}, 64'(host.meet_step), 64'(m));
    chk({tag, "_period"}, 64'(host.period), 64'(per));
    chk({tag, "_timeout"}, 64'(host.timeout), 64'(to));
    chk({tag, "_busy_low"}, 64'(host.busy), 64'd0);
    chk({tag, "_init_hold"}, 64'(init_state), 64'(x0));
    chk({tag, "_proto"}, 64'({proto_bad, busy_bad}), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(host.done), 64'd0);
    chk({tag, "_meet_hold"}, 64'(host.meet_step), 64'(m));
  endtask

  task automatic load_identity();
    for (int i = 0; i < 256; i++) f_tab[i] = 8'(i);
  endtask

  task automatic load_counter3();
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      f_tab[i] = {v[7:3], v[2:0] + 3'd1};
    end
  endtask

  initial begin
    rst = 1'b1;
    host.start = 1'b0;
    host.init_in = '0;
    load_identity();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        64'({host.busy, host.done, host.meet_step, host.period, host.timeout,
             init_state, reset_nos, start_s0, start_s1}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fixed point
    load_identity();
    run_case("fixed", 8'h5A, 1'b0, 1'b0);
    chk("fixed_const_lat", 64'(last_cyc), 64'd8);
    chk("fixed_const_meet", 64'(host.meet_step), 64'd2);
    chk("fixed_const_period", 64'(host.period), 64'd1);

    // 3-bit up-counter
    load_counter3();
    run_case("cnt3", 8'h00, 1'b0, 1'b0);
`ifdef GNR_CYCLE_TIMEOUT_EN
    chk("cnt3_const_lat", 64'(last_cyc), 64'd22);
    chk("cnt3_const_timeout", 64'(host.timeout), 64'd1);
    chk("cnt3_const_period", 64'(host.period), 64'd0);
`else
    chk("cnt3_const_lat", 64'(last_cyc), 64'd50);
    chk("cnt3_const_meet", 64'(host.meet_step), 64'd16);
    chk("cnt3_const_period", 64'(host.period), 64'd8);
`endif

    // a->b->c->d->b
    load_identity();
    f_tab[8'h10] = 8'h20;
    f_tab[8'h20] = 8'h30;
    f_tab[8'h30] = 8'h40;
    f_tab[8'h40] = 8'h20;
    run_case("path", 8'h10, 1'b0, 1'b0);
    chk("path_const_lat", 64'(last_cyc), 64'd20);
    chk("path_const_meet", 64'(host.meet_step), 64'd6);
    chk("path_const_period", 64'(host.period), 64'd3);

    // start pulsed during STEP1 must be ignored
    load_counter3();
    run_case("inject", 8'h00, 1'b1, 1'b0);

    // rst in STEP2, then a fresh run
    run_case("rst_step2", 8'h00, 1'b0, 1'b1);
    run_case("after_rst", 8'h03, 1'b0, 1'b0);

    // Random maps and initial states
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 256; i++) f_tab[i] = 8'($urandom_range(0, 255));
      run_case($sformatf("rand%0d", r), 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
